voice_engine: RTL and testbench
===============================

# voice_engine

Parametrised polyphonic voice engine: NUM_VOICES voices, each with its own phase accumulator, explicit five-state ADSR envelope and velocity. On each SAMPLE_REQ it scans every voice once through a two-stage pipeline against an external wavetable, and sums the scaled samples into a saturating accumulator. The mixed sample is delivered over a valid/ready handshake. It sits between the MIDI/Avalon note interface and the audio output FIFO/codec serialiser.

## Interface
- NUM_VOICES, 128: voice count; VOICE_W = $clog2(NUM_VOICES)
- PHASE_W, 24: phase accumulator width
- ADDR_W, 12: wavetable address width; WT_ADDR = phase[PHASE_W-1 -: ADDR_W]
- AMP_W, 21: envelope amplitude width (unsigned)
- VEL_W, 7: velocity width
- ACC_W, 32: mix accumulator/output width, must be ≥ 32
- CLK  in  1  sole clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- NOTE_VALID / NOTE_READY  in/out  1  note event handshake
- NOTE_KEY  in  VOICE_W  voice index
- NOTE_VEL  in  VEL_W  velocity; 0 = note-off
- PEAK_ATT, PEAK_SUS, ATT_STEP, DEC_STEP, SUS_STEP, REL_STEP  in  AMP_W each  envelope controls, quasi-static
- SAMPLE_REQ  in  1  one-cycle pulse starting a scan
- VOICE_IDX  out  VOICE_W  voice in the issue stage
- PINC  in  PHASE_W  phase increment for VOICE_IDX (combinational, same cycle)
- WT_ADDR  out  ADDR_W  registered wavetable address
- WT_DATA  in  16  signed sample for WT_ADDR, valid the cycle after WT_ADDR changes
- SAMPLE_OUT  out  ACC_W  signed mixed sample
- SAMPLE_VALID / SAMPLE_READY  out/in  1  output handshake
- ACTIVE_VOICES  out  VOICE_W+1  count of non-IDLE voices seen in the last scan
- OVERRUN  out  1  sticky; set when SAMPLE_REQ is ignored

## Operation
- Per-voice storage: env state (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), amp[AMP_W], phase[PHASE_W], vel[VEL_W]. RESET_N clears env to IDLE and amp to 0. Phase and vel are not reset.
- FSM states: S_IDLE, S_SCAN, S_DRAIN, S_OUT.
  - S_IDLE: NOTE_READY=1. SAMPLE_REQ moves to S_SCAN, clears the accumulator and the voice counter.
  - S_SCAN: issues one voice per cycle, indices 0..NUM_VOICES-1, then moves to S_DRAIN.
  - S_DRAIN: one cycle to accumulate the last voice, then moves to S_OUT.
  - S_OUT: SAMPLE_VALID=1 until SAMPLE_READY, then returns to S_IDLE.
- Note event, accepted only when NOTE_VALID && NOTE_READY:
  - NOTE_VEL≠0: vel←NOTE_VEL, env←ATTACK. Phase←0 only if the voice was IDLE; on retrigger, phase and amp are kept.
  - NOTE_VEL=0: a non-IDLE voice goes to RELEASE. An IDLE voice is unchanged.
- Issue stage, voice v. Next amp/env are written back the same cycle:
  - ATTACK: a=amp+ATT_STEP (AMP_W+1 bits). If a ≥ PEAK_ATT: amp←PEAK_ATT, go to DECAY.
  - DECAY: if amp ≤ PEAK_SUS+DEC_STEP: amp←PEAK_SUS, go to SUSTAIN. Else amp−=DEC_STEP.
  - SUSTAIN: amp←max(amp−SUS_STEP, 0). Stays in SUSTAIN until note-off.
  - RELEASE: if amp ≤ REL_STEP: amp←0, go to IDLE. Else amp−=REL_STEP.
  - Non-IDLE voices: phase←phase+PINC, wrapping mod 2^PHASE_W. Write WT_ADDR from the pre-increment phase.
  - Gain: gain = top 16 bits of (new amp × vel), i.e. product[AMP_W+VEL_W-1 -: 16]. Registered with an active flag. IDLE voices get gain 0.
- Accumulate stage, one cycle later: contrib = signed WT_DATA × {0,gain} (32b signed), sign-extended to ACC_W. acc←acc+contrib, clamped to ±full-scale on signed overflow.
- ACTIVE_VOICES is updated at S_DRAIN→S_OUT with the count of voices whose pre-update env was non-IDLE.
- A SAMPLE_REQ in any state other than S_IDLE is ignored and sets OVERRUN. OVERRUN is cleared only by reset.

## Timing
- Reset values:
  - FSM=S_IDLE; SAMPLE_OUT=0, SAMPLE_VALID=0.
  - NOTE_READY=1, WT_ADDR=0, VOICE_IDX=0.
  - ACTIVE_VOICES=0, OVERRUN=0.
- Asserting RESET_N mid-scan aborts immediately with all of the values above.
- Scan latency: from the SAMPLE_REQ cycle to SAMPLE_VALID is NUM_VOICES+2 cycles (130 at default).
- SAMPLE_OUT is stable while SAMPLE_VALID=1. The transfer completes on the cycle SAMPLE_VALID && SAMPLE_READY. SAMPLE_READY may be held high permanently.
- Note events are not accepted during S_SCAN/S_DRAIN/S_OUT, so no voice is modified mid-scan.
- Simultaneous NOTE_VALID and SAMPLE_REQ in S_IDLE: the note is applied and the scan starts the same cycle. The scan sees the updated voice.

## Test plan
- Reset, then SAMPLE_REQ with no notes; SAMPLE_READY=1 → SAMPLE_VALID high 130 cycles after SAMPLE_REQ, SAMPLE_OUT=0, ACTIVE_VOICES=0.
- Note key 60, vel 127; ATT_STEP=0x40000, PEAK_ATT=0x100000; WT_DATA forced to 0x4000 → amp reaches PEAK_ATT after scan 4. DECAY begins at scan 5. SAMPLE_OUT grows monotonically.
- Same voice, PINC=0x001000 → WT_ADDR for voice 60 advances by 1 per scan. At phase 0xFFF000 it wraps to 0.
- Two notes, both SUSTAIN, WT_DATA=0x7FFF, amp and vel at max, ACC_W=32 → SAMPLE_OUT saturates at 0x7FFFFFFF with no wrap.
- Note-off during SUSTAIN with REL_STEP > amp → voice goes IDLE in 1 scan. ACTIVE_VOICES drops by 1 on the next scan.
- SAMPLE_REQ during S_SCAN, and SAMPLE_READY held low for 10 cycles → OVERRUN=1, SAMPLE_OUT held, exactly one handshake transfer; RESET_N low mid-scan → all outputs return to reset values.

Source files
------------

// File: rtl/voice_engine.sv
// Polyphonic voice engine: per-voice ADSR/phase state, a two-stage issue/accumulate
// scan against an external wavetable, and a saturating mix delivered over valid/ready.
module voice_engine #(
    parameter int NUM_VOICES = 128,
    parameter int VOICE_W    = $clog2(NUM_VOICES),
    parameter int PHASE_W    = 24,
    parameter int ADDR_W     = 12,
    parameter int AMP_W      = 21,
    parameter int VEL_W      = 7,
    parameter int ACC_W      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      note_valid_i,
    output logic                      note_ready_o,
    input  logic [VOICE_W-1:0]        note_key_i,
    input  logic [VEL_W-1:0]          note_vel_i,
    input  logic [AMP_W-1:0]          peak_att_i,
    input  logic [AMP_W-1:0]          peak_sus_i,
    input  logic [AMP_W-1:0]          att_step_i,
    input  logic [AMP_W-1:0]          dec_step_i,
    input  logic [AMP_W-1:0]          sus_step_i,
    input  logic [AMP_W-1:0]          rel_step_i,
    input  logic                      sample_req_i,
    output logic [VOICE_W-1:0]        voice_idx_o,
    input  logic [PHASE_W-1:0]        pinc_i,
    output logic [ADDR_W-1:0]         wt_addr_o,
    input  logic signed [15:0]        wt_data_i,
    output logic signed [ACC_W-1:0]   sample_out_o,
    output logic                      sample_valid_o,
    input  logic                      sample_ready_i,
    output logic [VOICE_W:0]          active_voices_o,
    output logic                      overrun_o
);

    typedef enum logic [2:0] {E_IDLE, E_ATTACK, E_DECAY, E_SUSTAIN, E_RELEASE} env_e;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_OUT} state_e;

    localparam int PROD_W = AMP_W + VEL_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    env_e               env_q   [NUM_VOICES];
    logic [AMP_W-1:0]   amp_q   [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [VEL_W-1:0]   vel_q   [NUM_VOICES];

    state_e                   state_q, state_d;
    logic [VOICE_W-1:0]       voice_idx_q, voice_idx_d;
    logic [VOICE_W:0]         cnt_q, cnt_d, active_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d, sample_q;
    logic [ADDR_W-1:0]        wt_addr_q;
    logic [15:0]              gain_q;
    logic                     act_q, vld_q, overrun_q;
    logic                     issue, note_fire;

    // Issue stage: envelope step for the voice under VOICE_IDX
    env_e               cur_env, nxt_env;
    logic [AMP_W-1:0]   cur_amp, nxt_amp;
    logic [PHASE_W-1:0] cur_phase;
    logic [VEL_W-1:0]   cur_vel;
    logic [AMP_W:0]     att_sum, dec_lim;
    logic [PROD_W-1:0]  prod_av;
    logic [15:0]        gain_d;
    logic               cur_active;

    assign note_fire  = note_valid_i && note_ready_o;
    assign cur_env    = env_q[voice_idx_q];
    assign cur_amp    = amp_q[voice_idx_q];
    assign cur_phase  = phase_q[voice_idx_q];
    assign cur_vel    = vel_q[voice_idx_q];
    assign cur_active = (cur_env != E_IDLE);
    assign att_sum    = {1'b0, cur_amp} + {1'b0, att_step_i};
    assign dec_lim    = {1'b0, peak_sus_i} + {1'b0, dec_step_i};

    always_comb begin
        nxt_env = cur_env;
        nxt_amp = cur_amp;
        case (cur_env)
            E_ATTACK:
                if (att_sum >= {1'b0, peak_att_i}) begin
                    nxt_amp = peak_att_i;
                    nxt_env = E_DECAY;
                end else begin
                    nxt_amp = att_sum[AMP_W-1:0];
                end
            E_DECAY:
                if ({1'b0, cur_amp} <= dec_lim) begin
                    nxt_amp = peak_sus_i;
                    nxt_env = E_SUSTAIN;
                end else begin
                    nxt_amp = cur_amp - dec_step_i;
                end
            E_SUSTAIN:
                nxt_amp = (cur_amp > sus_step_i) ? cur_amp - sus_step_i : '0;
            E_RELEASE:
                if (cur_amp <= rel_step_i) begin
                    nxt_amp = '0;
                    nxt_env = E_IDLE;
                end else begin
                    nxt_amp = cur_amp - rel_step_i;
                end
            default: ;
        endcase
    end

    assign prod_av = PROD_W'(nxt_amp) * PROD_W'(cur_vel);
    assign gain_d  = cur_active ? 16'(prod_av >> (PROD_W - 16)) : '0;

    // Accumulate stage: product magnitude always fits 32 bits, so truncation is exact
    logic signed [31:0]      wt_ext, gain_ext, contrib;
    logic signed [ACC_W-1:0] contrib_ext, sum;
    logic                    ovf;

    assign wt_ext      = 32'(wt_data_i);
    assign gain_ext    = {16'b0, gain_q};
    assign contrib     = wt_ext * gain_ext;
    assign contrib_ext = ACC_W'(contrib);
    assign sum         = acc_q + contrib_ext;
    assign ovf         = (acc_q[ACC_W-1] == contrib_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d     = state_q;
        voice_idx_d = voice_idx_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        issue       = 1'b0;
        if (vld_q && act_q)
            acc_d = ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
        case (state_q)
            S_IDLE:
                if (sample_req_i) begin
                    state_d     = S_SCAN;
                    voice_idx_d = '0;
                    cnt_d       = '0;
                    acc_d       = '0;
                end
            S_SCAN: begin
                issue = 1'b1;
                if (cur_active) cnt_d = cnt_q + (VOICE_W+1)'(1);
                if (voice_idx_q == VOICE_W'(NUM_VOICES-1)) begin
                    state_d     = S_DRAIN;
                    voice_idx_d = '0;
                end else begin
                    voice_idx_d = voice_idx_q + VOICE_W'(1);
                end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT:   if (sample_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            voice_idx_q <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            active_q    <= '0;
            sample_q    <= '0;
            wt_addr_q   <= '0;
            gain_q      <= '0;
            act_q       <= 1'b0;
            vld_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            voice_idx_q <= voice_idx_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            vld_q       <= issue;
            if (issue) begin
                gain_q <= gain_d;
                act_q  <= cur_active;
                if (cur_active) wt_addr_q <= cur_phase[PHASE_W-1 -: ADDR_W];
            end
            if (state_q == S_DRAIN) begin
                active_q <= cnt_q;
                sample_q <= acc_d;
            end
            if (sample_req_i && state_q != S_IDLE) overrun_q <= 1'b1;
        end
    end

    // Note events and scan write-back never coincide: notes only land in S_IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                env_q[i] <= E_IDLE;
                amp_q[i] <= '0;
            end
        end else if (note_fire) begin
            if (note_vel_i != '0)
                env_q[note_key_i] <= E_ATTACK;
            else if (env_q[note_key_i] != E_IDLE)
                env_q[note_key_i] <= E_RELEASE;
        end else if (issue) begin
            env_q[voice_idx_q] <= nxt_env;
            amp_q[voice_idx_q] <= nxt_amp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (note_fire && note_vel_i != '0) begin
            vel_q[note_key_i] <= note_vel_i;
            if (env_q[note_key_i] == E_IDLE) phase_q[note_key_i] <= '0;
        end else if (issue && cur_active) begin
            phase_q[voice_idx_q] <= cur_phase + pinc_i;
        end
    end

    assign note_ready_o    = (state_q == S_IDLE);
    assign sample_valid_o  = (state_q == S_OUT);
    assign sample_out_o    = sample_q;
    assign voice_idx_o     = voice_idx_q;
    assign wt_addr_o       = wt_addr_q;
    assign active_voices_o = active_q;
    assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_voice_engine.sv
// Bench for voice_engine: directed envelope/phase/saturation/overrun scenarios plus
// randomized notes and envelope settings, scored against a per-scan voice model.
module tb_voice_engine;

    localparam int NV  = 128;
    localparam int VW  = 7;
    localparam int PW  = 24;
    localparam int AW  = 12;
    localparam int AMW = 21;
    localparam int VLW = 7;
    localparam int ACW = 32;

    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic                  clk, rst_n;
    logic                  note_valid, note_ready;
    logic [VW-1:0]         note_key;
    logic [VLW-1:0]        note_vel;
    logic [AMW-1:0]        peak_att, peak_sus, att_step, dec_step, sus_step, rel_step;
    logic                  sample_req;
    logic [VW-1:0]         voice_idx;
    logic [PW-1:0]         pinc;
    logic [AW-1:0]         wt_addr;
    logic signed [15:0]    wt_data;
    logic signed [ACW-1:0] sample_out;
    logic                  sample_valid, sample_ready;
    logic [VW:0]           active_voices;
    logic                  overrun;

    logic [PW-1:0]      pinc_tab [NV];
    logic signed [15:0] wt_mem   [1 << AW];
    logic               wt_const_en;
    logic signed [15:0] wt_const;

    assign pinc    = pinc_tab[voice_idx];
    assign wt_data = wt_const_en ? wt_const : wt_mem[wt_addr];

    voice_engine dut (
        .clk_i(clk), .rst_ni(rst_n),
        .note_valid_i(note_valid), .note_ready_o(note_ready),
        .note_key_i(note_key), .note_vel_i(note_vel),
        .peak_att_i(peak_att), .peak_sus_i(peak_sus),
        .att_step_i(att_step), .dec_step_i(dec_step),
        .sus_step_i(sus_step), .rel_step_i(rel_step),
        .sample_req_i(sample_req), .voice_idx_o(voice_idx),
        .pinc_i(pinc), .wt_addr_o(wt_addr), .wt_data_i(wt_data),
        .sample_out_o(sample_out), .sample_valid_o(sample_valid),
        .sample_ready_i(sample_ready), .active_voices_o(active_voices),
        .overrun_o(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: one entry per voice, advanced a whole scan at a time
    int     m_env   [NV];
    longint m_amp   [NV];
    longint m_phase [NV];
    int     m_vel   [NV];
    int     m_active;
    longint m_out;
    longint m_addr;

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_env[v] = M_IDLE;
            m_amp[v] = 0;
        end
        m_active = 0;
        m_out    = 0;
        m_addr   = 0;
    endfunction

    function automatic void model_note(input int key, input int vel);
        if (vel != 0) begin
            if (m_env[key] == M_IDLE) m_phase[key] = 0;
            m_vel[key] = vel;
            m_env[key] = M_ATT;
        end else if (m_env[key] != M_IDLE) begin
            m_env[key] = M_REL;
        end
    endfunction

    function automatic longint wt_val(input longint a);
        return wt_const_en ? longint'(wt_const) : longint'(wt_mem[a]);
    endfunction

    function automatic void model_scan();
        longint acc, gain, a;
        int cnt;
        acc = 0;
        cnt = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_env[v] == M_IDLE) continue;
            cnt++;
            a          = m_phase[v] >> (PW - AW);
            m_addr     = a;
            m_phase[v] = (m_phase[v] + longint'(pinc_tab[v])) % (64'd1 << PW);
            case (m_env[v])
                M_ATT: if (m_amp[v] + att_step >= peak_att) begin
                           m_amp[v] = peak_att; m_env[v] = M_DEC;
                       end else m_amp[v] += att_step;
                M_DEC: if (m_amp[v] <= longint'(peak_sus) + dec_step) begin
                           m_amp[v] = peak_sus; m_env[v] = M_SUS;
                       end else m_amp[v] -= dec_step;
                M_SUS: m_amp[v] = (m_amp[v] > sus_step) ? m_amp[v] - sus_step : 0;
                M_REL: if (m_amp[v] <= rel_step) begin
                           m_amp[v] = 0; m_env[v] = M_IDLE;
                       end else m_amp[v] -= rel_step;
                default: ;
            endcase
            gain = (m_amp[v] * m_vel[v]) >> (AMW + VLW - 16);
            acc += wt_val(a) * gain;
            if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        m_active = cnt;
        m_out    = acc;
    endfunction

    task automatic send_note(input int key, input int vel);
        @(negedge clk);
        check("note_ready", note_ready, 1);
        note_valid = 1'b1;
        note_key   = key[VW-1:0];
        note_vel   = vel[VLW-1:0];
        model_note(key, vel);
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic do_scan(input bit note_en, input int key, input int vel,
                           input int hold, input int ovr_at);
        int lat, bad, xf;
        logic signed [ACW-1:0] held;
        @(negedge clk);
        if (note_en) begin
            note_valid = 1'b1;
            note_key   = key[VW-1:0];
            note_vel   = vel[VLW-1:0];
            model_note(key, vel);
        end
        sample_req   = 1'b1;
        sample_ready = (hold == 0);
        @(negedge clk);
        note_valid = 1'b0;
        sample_req = 1'b0;
        model_scan();
        lat = 1;
        while (!sample_valid && lat < 1000) begin
            if (lat == ovr_at) sample_req = 1'b1;
            @(negedge clk);
            sample_req = 1'b0;
            lat++;
        end
        check("latency", lat, NV + 2);
        check("sample_out", sample_out, m_out);
        check("active_voices", active_voices, m_active);
        check("wt_addr", wt_addr, m_addr);
        if (hold > 0) begin
            held = sample_out;
            bad  = 0;
            repeat (hold) begin
                @(negedge clk);
                if (!sample_valid || sample_out !== held) bad++;
            end
            check("hold_stable", bad, 0);
            sample_ready = 1'b1;
        end
        xf = 0;
        repeat (4) begin
            if (sample_valid && sample_ready) xf++;
            @(negedge clk);
        end
        check("xfer_count", xf, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_note_ready", note_ready, 1);
        check("rst_wt_addr", wt_addr, 0);
        check("rst_voice_idx", voice_idx, 0);
        check("rst_active", active_voices, 0);
        check("rst_overrun", overrun, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint prev;
        int     a1, nn, k, vl;
        int     exp_addr [6];
        exp_addr = '{0, 1, 2, 3, 'hFFF, 0};

        rst_n = 1'b0; note_valid = 1'b0; note_key = '0; note_vel = '0;
        sample_req = 1'b0; sample_ready = 1'b1;
        peak_att = '0; peak_sus = '0; att_step = '0; dec_step = '0; sus_step = '0; rel_step = '0;
        for (int i = 0; i < NV; i++) pinc_tab[i] = '0;
        for (int i = 0; i < (1 << AW); i++) wt_mem[i] = 16'($urandom);
        wt_const_en = 1'b1;
        wt_const    = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Empty scan
        do_scan(0, 0, 0, 0, 0);
        check("empty_out", sample_out, 0);

        // Attack ramp and phase stepping/wrap on voice 60; first note rides with the request
        att_step = 21'h40000; peak_att = 21'h100000; peak_sus = 21'h80000;
        dec_step = 21'h10000; sus_step = '0;         rel_step = 21'h8000;
        wt_const = 16'sh4000;
        pinc_tab[60] = 24'h001000;
        prev = 0;
        for (int s = 0; s < 6; s++) begin
            if (s == 3) pinc_tab[60] = 24'hFFC000;
            if (s == 4) pinc_tab[60] = 24'h001000;
            do_scan(s == 0, 60, 127, 0, 0);
            check("wt_addr_seq", wt_addr, exp_addr[s]);
            if (s < 4) check("attack_mono", sample_out > prev, 1);
            if (s == 3) check("attack_peak", sample_out, 64'd16384 * ((64'd1048576 * 127) >> 12));
            prev = sample_out;
        end

        // Second voice, then release voice 60 from sustain
        dec_step = 21'h100000;
        send_note(3, 100);
        repeat (3) do_scan(0, 0, 0, 0, 0);
        rel_step = 21'h1FFFFF;
        send_note(60, 0);
        do_scan(0, 0, 0, 0, 0);
        a1 = int'(active_voices);
        do_scan(0, 0, 0, 0, 0);
        check("active_drop", active_voices, a1 - 1);

        // Full-scale voices drive the mix into both saturation rails
        peak_att = 21'h1FFFFF; peak_sus = 21'h1FFFFF; att_step = 21'h1FFFFF;
        dec_step = '0; sus_step = '0;
        wt_const = 16'sh7FFF;
        send_note(10, 127);
        send_note(11, 127);
        repeat (2) do_scan(0, 0, 0, 0, 0);
        check("sat_pos", sample_out, 64'sh7FFFFFFF);
        check("overrun_clear", overrun, 0);
        wt_const = 16'sh8000;
        do_scan(0, 0, 0, 0, 0);
        check("sat_neg", sample_out, -64'sd2147483648);

        // Request during scan and a stalled consumer
        wt_const = 16'sh1234;
        do_scan(0, 0, 0, 10, 20);
        check("overrun_set", overrun, 1);

        // Randomized notes, envelope settings, wavetable and increments
        wt_const_en = 1'b0;
        for (int i = 0; i < NV; i++) pinc_tab[i] = 24'($urandom);
        repeat (12) begin
            peak_att = 21'($urandom_range(0, 21'h1FFFFF));
            peak_sus = 21'($urandom_range(0, 21'h1FFFFF));
            att_step = 21'($urandom_range(1, 21'h100000));
            dec_step = 21'($urandom_range(0, 21'h80000));
            sus_step = 21'($urandom_range(0, 21'h20000));
            rel_step = 21'($urandom_range(0, 21'h100000));
            nn = $urandom_range(0, 4);
            repeat (nn) begin
                k  = $urandom_range(0, 31);
                vl = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 127);
                send_note(k, vl);
            end
            k  = $urandom_range(0, 31);
            vl = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 127);
            do_scan($urandom_range(0, 1) == 1, k, vl, $urandom_range(0, 3), 0);
        end

        // Reset in the middle of a scan
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_scan(0, 0, 0, 0, 0);
        check("post_rst_active", active_voices, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
